fir_cfg_sequencer: RTL

Packet-level configuration controller between the config byte FIFO read port and the FIR filter coefficient register file. It pops header and payload bytes from the FIFO and decodes burst-write, clear and commit commands. It sequences single-cycle register writes with auto-incrementing addresses and flags malformed or stalled packets.

---
 rtl/fir_cfg_sequencer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/fir_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// fir_cfg_sequencer
//
// Packet-level configuration controller that sits between the read port of
// the configuration byte FIFO (first-word fall-through) and the FIR filter
// coefficient register file. It pops a header byte, decodes it and then
// either streams payload bytes into consecutive coefficient registers,
// clears the whole register file, or pulses a commit to the filter.
//
// Header byte layout:
//   [7:6] opcode   00 = BURST, 01 = COMMIT, 10 = CLEAR, 11 = reserved
//   [5:3] start register address (BURST only)
//   [2:0] payload length minus one (BURST only, 1..8 bytes)
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   synchronous active-high reset
//   Empty    in   FIFO empty flag
//   Data     in   FIFO read data, valid whenever Empty = 0
//   RINC     out  FIFO pop strobe (combinational)
//   WrEn     out  coefficient register write strobe
//   RegAddr  out  coefficient register write address
//   D7_D0    out  coefficient register write data
//   Commit   out  one-cycle pulse: load shadow coefficients into active set
//   Busy     out  a packet is in progress
//   Err      out  one-cycle pulse on reserved opcode or burst timeout
// -----------------------------------------------------------------------------
module fir_cfg_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        Empty,
    input  logic [7:0]                  Data,
    output logic                        RINC,
    output logic                        WrEn,
    output logic [$clog2(NUM_REGS)-1:0] RegAddr,
    output logic [7:0]                  D7_D0,
    output logic                        Commit,
    output logic                        Busy,
    output logic                        Err
);

    localparam int AW = $clog2(NUM_REGS);

    // Last value the stall counter holds before it trips.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_REGS - 1);

    localparam logic [1:0] OP_BURST  = 2'b00;
    localparam logic [1:0] OP_COMMIT = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CLEAR,
        S_COMMIT,
        S_ERR
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;       // next register to be written
    logic [3:0]    remain_q, remain_d;   // payload bytes still to pop (1..8)
    logic [7:0]    tmo_q, tmo_d;         // consecutive empty cycles inside a burst

    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          commit_q, commit_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic          pop;

    // Wrapping address increment so a burst may run past the last register.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == ADDR_LAST) ? '0 : a + AW'(1);
    endfunction

    // The FIFO is only read while waiting for a header or while streaming
    // payload; CLEAR, COMMIT and ERR never consume bytes.
    assign pop  = !RST && !Empty && ((state_q == S_IDLE) || (state_q == S_DATA));
    assign RINC = pop;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        tmo_d      = tmo_q;
        wr_en_d    = 1'b0;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        commit_d   = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Stall counter only runs inside a burst.
                tmo_d = '0;
                if (pop) begin
                    case (Data[7:6])
                        OP_BURST: begin
                            state_d  = S_DATA;
                            addr_d   = AW'(Data[5:3]);
                            remain_d = {1'b0, Data[2:0]} + 4'd1;
                        end
                        OP_COMMIT: begin
                            state_d  = S_COMMIT;
                            commit_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            state_d = S_CLEAR;
                            addr_d  = '0;
                        end
                        default: begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end

            S_DATA: begin
                if (pop) begin
                    // Write lands one cycle after the pop; if this was the
                    // last byte, that write appears in the first IDLE cycle,
                    // which may already pop the next header.
                    wr_en_d    = 1'b1;
                    reg_addr_d = addr_q;
                    wr_data_d  = Data;
                    addr_d     = next_addr(addr_q);
                    remain_d   = remain_q - 4'd1;
                    tmo_d      = '0;
                    if (remain_q == 4'd1) begin
                        state_d = S_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // This is the TIMEOUT-th consecutive empty cycle.
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            S_CLEAR: begin
                wr_en_d    = 1'b1;
                reg_addr_d = addr_q;
                wr_data_d  = 8'h00;
                addr_d     = next_addr(addr_q);
                if (addr_q == ADDR_LAST) begin
                    state_d = S_IDLE;
                end
            end

            S_COMMIT: begin
                state_d = S_IDLE;
            end

            S_ERR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            tmo_q      <= '0;
            wr_en_q    <= 1'b0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            commit_q   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            tmo_q      <= tmo_d;
            wr_en_q    <= wr_en_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            commit_q   <= commit_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign WrEn    = wr_en_q;
    assign RegAddr = reg_addr_q;
    assign D7_D0   = wr_data_q;
    assign Commit  = commit_q;
    assign Err     = err_q;
    assign Busy    = busy_q;

    // -------------------------------------------------------------------------
    // Structural invariants of the strobes
    // -------------------------------------------------------------------------
    a_one_strobe: assert property (@(posedge CLK) disable iff (RST)
        !(WrEn && Commit) && !(WrEn && Err) && !(Commit && Err));

    a_commit_pulse: assert property (@(posedge CLK) disable iff (RST)
        Commit |=> !Commit);

    a_err_pulse: assert property (@(posedge CLK) disable iff (RST)
        Err |=> (!Err && !WrEn));

endmodule
